crp16_alu_mc: RTL and testbench
===============================

CRP16_ALU_MC -- requirements
Module: crp16_alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width; legal values are powers of two, 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning the request is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a request this cycle.
REQ-006 The block SHALL have port op_a, input, WIDTH bits, meaning operand A.
REQ-007 The block SHALL have port op_b, input, WIDTH bits, meaning operand B.
REQ-008 The block SHALL have port op_sel, input, 4 bits, meaning operation select.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning the result is held.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-011 The block SHALL have port alu_out, output, WIDTH bits, meaning the primary result (low product, quotient).
REQ-012 The block SHALL have port alu_hi, output, WIDTH bits, meaning the secondary result (high product, remainder, else 0).
REQ-013 The block SHALL have ports v, c, n, z, outputs, 1 bit each, meaning overflow, carry, negative and zero flags.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 Accept (IDLE, in_valid=1) SHALL capture op_a, op_b and op_sel; ops 0-7 go to DONE next cycle (latency 1); ops 8-9 go to BUSY.
REQ-016 BUSY SHALL run exactly WIDTH iterations (one bit per cycle), then DONE; latency from accept to out_valid is WIDTH+1 cycles.
REQ-017 DONE with out_ready=1 SHALL return to IDLE next cycle; outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE; no back-to-back overlap (one request in flight).
REQ-019 Op 0 (add) SHALL give a+b, c=carry out, v=signed overflow (same-sign operands, result sign differs).
REQ-020 Op 1 (sub) SHALL give a+~b+1, c=carry out of that sum, v=1 when operand signs differ and the result sign equals b's sign.
REQ-021 Ops 2/3/4 (lsr/asr/lsl) SHALL shift a by b[log2(WIDTH)-1:0]; upper bits of b SHALL be ignored; c=v=0.
REQ-022 Ops 5/6/7 SHALL give a AND b, a OR b and a XOR b; c=v=0.
REQ-023 Op 8 (unsigned multiply) SHALL give {alu_hi,alu_out}=a*b at 2*WIDTH bits; c=1 if alu_hi is nonzero; v=0.
REQ-024 Op 9 (unsigned divide, restoring) SHALL give alu_out=a/b and alu_hi=a%b; c=0, v=0.
REQ-025 Op 9 with b=0 SHALL still take WIDTH+1 cycles and give alu_out=all ones, alu_hi=a, v=1, c=0.
REQ-026 Ops 10-15 SHALL complete in 1 cycle with alu_out=0, alu_hi=0, c=0, v=1 (illegal-op marker).
REQ-027 alu_hi SHALL be 0 for ops 0-7; n SHALL equal alu_out[WIDTH-1]; z SHALL be 1 iff alu_out=0 (alu_hi excluded).
REQ-028 All outputs except in_ready SHALL be driven from registers; in_ready SHALL be decoded from the state register only.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE, in_ready=1, out_valid=0, alu_out=0, alu_hi=0, v=c=n=0, z=1.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation; the result SHALL be discarded and no out_valid pulse SHALL occur.
REQ-031 The first accept SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-032 WIDTH=16, op 0, a=0x7FFF, b=0x0001 -> one cycle later out_valid=1, alu_out=0x8000, v=1, c=0, n=1, z=0.
REQ-033 WIDTH=16, op 1, a=0x0000, b=0x0001 -> alu_out=0xFFFF, c=0, v=0, n=1; op 3, a=0x8000, b=0x0014 -> alu_out=0xF800 (shift 4).
REQ-034 WIDTH=16, op 8, a=0xFFFF, b=0xFFFF -> out_valid exactly 17 cycles after accept, alu_hi=0xFFFE, alu_out=0x0001, c=1.
REQ-035 WIDTH=16, op 9, a=100, b=7 -> alu_out=14, alu_hi=2; b=0 -> alu_out=0xFFFF, alu_hi=100, v=1, also 17 cycles.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE next cycle.
REQ-037 Assert reset_n=0 mid-BUSY (cycle 8 of op 8) -> immediate reset values; after release a new op 0 completes correctly.

Source files
------------

// File: rtl/crp16_alu_mc.sv
// crp16_alu_mc - multi-cycle ALU with a valid/ready request and result handshake.
//
// Ops 0-7 (add, sub, lsr, asr, lsl, and, or, xor) and the illegal ops 10-15
// finish one cycle after accept. Op 8 (unsigned multiply) and op 9 (unsigned
// restoring divide) iterate one bit per cycle for WIDTH cycles.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready    request handshake; in_ready is high only when idle
//   op_a, op_b, op_sel    operands and 4-bit operation select
//   out_valid, out_ready  result handshake; result holds until out_ready
//   alu_out, alu_hi       primary result / secondary result (high product, remainder)
//   v, c, n, z            overflow, carry, negative, zero flags
module crp16_alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic             v,
  output logic             c,
  output logic             n,
  output logic             z
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, next_state;

  logic             accept;
  logic             long_op;
  logic             last_step;
  logic [SW-1:0]    count;
  logic             is_div;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] quick_res;
  logic             quick_c;
  logic             quick_v;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && (state == IDLE);
  assign long_op   = (op_sel == 4'd8) || (op_sel == 4'd9);
  assign last_step = (count == SW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = long_op ? BUSY : DONE;
      BUSY:    if (last_step) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Single-cycle ops are evaluated straight from the input operands at accept.
  assign add_sum = {1'b0, op_a} + {1'b0, op_b};
  assign sub_sum = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
  assign shamt   = op_b[SW-1:0];

  always_comb begin
    quick_res = '0;
    quick_c   = 1'b0;
    quick_v   = 1'b0;
    case (op_sel)
      4'd0: begin
        quick_res = add_sum[WIDTH-1:0];
        quick_c   = add_sum[WIDTH];
        quick_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'd1: begin
        quick_res = sub_sum[WIDTH-1:0];
        quick_c   = sub_sum[WIDTH];
        quick_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_sum[WIDTH-1] == op_b[WIDTH-1]);
      end
      4'd2: quick_res = op_a >> shamt;
      4'd3: quick_res = $signed(op_a) >>> shamt;
      4'd4: quick_res = op_a << shamt;
      4'd5: quick_res = op_a & op_b;
      4'd6: quick_res = op_a | op_b;
      4'd7: quick_res = op_a ^ op_b;
      4'd8, 4'd9: quick_res = '0;
      default: quick_v = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  // Multiply: acc_lo holds the multiplier, shifting right as the product's
  // low half fills in from the top. Divide: acc_lo holds the dividend,
  // shifting left into the remainder while quotient bits enter at the bottom.
  // With b=0 every trial subtract succeeds, so the quotient is all ones and
  // the remainder ends up equal to the dividend without special-casing.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      alu_hi    <= '0;
      v         <= 1'b0;
      c         <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b1;
      count     <= '0;
      is_div    <= 1'b0;
      b_q       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_div <= (op_sel == 4'd9);
            b_q    <= op_b;
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= op_a;
            if (!long_op) begin
              out_valid <= 1'b1;
              alu_out   <= quick_res;
              alu_hi    <= '0;
              v         <= quick_v;
              c         <= quick_c;
              n         <= quick_res[WIDTH-1];
              z         <= (quick_res == '0);
            end
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + SW'(1);
          if (last_step) begin
            out_valid <= 1'b1;
            alu_out   <= step_lo;
            alu_hi    <= step_hi;
            v         <= is_div && (b_q == '0);
            c         <= !is_div && (step_hi != '0);
            n         <= step_lo[WIDTH-1];
            z         <= (step_lo == '0);
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_crp16_alu_mc.sv
module tb_crp16_alu_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  op_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_out;
  logic [15:0] alu_hi;
  logic        v, c, n, z;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [15:0] hi;
    logic [3:0]  vcnz;
    int          lat;
  } vec_t;

  crp16_alu_mc #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sel    (op_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .alu_hi    (alu_hi),
    .v         (v),
    .c         (c),
    .n         (n),
    .z         (z)
  );

  always #5 clk = ~clk;

  // Present one request, then count cycles from the accept edge until
  // out_valid rises (bounded).
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int cycles);
    @(negedge clk);
    op_sel   = op;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cycles   = 1;
    while (!out_valid && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sel    = '0;
    #12;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL reset_handshake: got %b expected 10", {in_ready, out_valid});
    end
    total++;
    if ({alu_hi, alu_out} !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_result: got %h expected 00000000", {alu_hi, alu_out});
    end
    total++;
    if ({v, c, n, z} !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 0001", {v, c, n, z});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_cycle();
    vec_t tbl[14];
    int   cyc;
    tbl = '{
      '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0, 4'b1010, 1},
      '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0, 4'b0101, 1},
      '{4'd1,  16'h0000, 16'h0001, 16'hFFFF, 16'h0, 4'b0010, 1},
      '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 16'h0, 4'b1100, 1},
      '{4'd1,  16'h0005, 16'h0005, 16'h0000, 16'h0, 4'b0101, 1},
      '{4'd2,  16'h8000, 16'h0014, 16'h0800, 16'h0, 4'b0000, 1},
      '{4'd3,  16'h8000, 16'h0014, 16'hF800, 16'h0, 4'b0010, 1},
      '{4'd4,  16'h0001, 16'h0013, 16'h0008, 16'h0, 4'b0000, 1},
      '{4'd4,  16'h8001, 16'h0010, 16'h8001, 16'h0, 4'b0010, 1},
      '{4'd5,  16'hF0F0, 16'hFF00, 16'hF000, 16'h0, 4'b0010, 1},
      '{4'd6,  16'hF0F0, 16'hFF00, 16'hFFF0, 16'h0, 4'b0010, 1},
      '{4'd7,  16'hF0F0, 16'hF0F0, 16'h0000, 16'h0, 4'b0001, 1},
      '{4'd12, 16'h1234, 16'h5678, 16'h0000, 16'h0, 4'b1001, 1},
      '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0, 4'b1001, 1}
    };
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
      total++;
      if (cyc !== tbl[i].lat) begin
        bad++;
        $display("[TB] FAIL single_latency op%0d: got %0d expected %0d", tbl[i].op, cyc, tbl[i].lat);
      end
      total++;
      if (alu_out !== tbl[i].out || alu_hi !== tbl[i].hi) begin
        bad++;
        $display("[TB] FAIL single_result op%0d a=%h b=%h: got %h/%h expected %h/%h",
                 tbl[i].op, tbl[i].a, tbl[i].b, alu_hi, alu_out, tbl[i].hi, tbl[i].out);
      end
      total++;
      if ({v, c, n, z} !== tbl[i].vcnz) begin
        bad++;
        $display("[TB] FAIL single_flags op%0d a=%h b=%h: got %b expected %b",
                 tbl[i].op, tbl[i].a, tbl[i].b, {v, c, n, z}, tbl[i].vcnz);
      end
      take_result();
    end
  endtask

  task automatic test_multicycle();
    vec_t tbl[7];
    int   cyc;
    tbl = '{
      '{4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0100, 17},
      '{4'd8, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 4'b0000, 17},
      '{4'd8, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0001, 17},
      '{4'd9, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 17},
      '{4'd9, 16'd100,  16'd0,    16'hFFFF, 16'd100,  4'b1010, 17},
      '{4'd9, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 4'b0001, 17},
      '{4'd9, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0010, 17}
    };
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
      total++;
      if (cyc !== tbl[i].lat) begin
        bad++;
        $display("[TB] FAIL multi_latency op%0d: got %0d expected %0d", tbl[i].op, cyc, tbl[i].lat);
      end
      total++;
      if (alu_out !== tbl[i].out || alu_hi !== tbl[i].hi) begin
        bad++;
        $display("[TB] FAIL multi_result op%0d a=%h b=%h: got %h/%h expected %h/%h",
                 tbl[i].op, tbl[i].a, tbl[i].b, alu_hi, alu_out, tbl[i].hi, tbl[i].out);
      end
      total++;
      if ({v, c, n, z} !== tbl[i].vcnz) begin
        bad++;
        $display("[TB] FAIL multi_flags op%0d a=%h b=%h: got %b expected %b",
                 tbl[i].op, tbl[i].a, tbl[i].b, {v, c, n, z}, tbl[i].vcnz);
      end
      take_result();
    end
  endtask

  task automatic test_hold();
    int cyc;
    run_op(4'd6, 16'h00F0, 16'h0F00, cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      op_sel    = 4'd0;
      op_a      = 16'h0001;
      op_b      = 16'h0001;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({out_valid, in_ready} !== 2'b10) begin
        bad++;
        $display("[TB] FAIL hold_handshake cycle %0d: got %b expected 10", i, {out_valid, in_ready});
      end
      total++;
      if (alu_out !== 16'h0FF0 || {v, c, n, z} !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL hold_result cycle %0d: got %h/%b expected 0ff0/0000", i, alu_out, {v, c, n, z});
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL hold_release: got %b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    op_sel   = 4'd8;
    op_a     = 16'hFFFF;
    op_b     = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, alu_hi, alu_out, v, c, n, z} !== {2'b10, 32'h0, 4'b0001}) begin
      bad++;
      $display("[TB] FAIL busy_reset_state: got %b %b %h %h %b expected 1 0 0000 0000 0001",
               in_ready, out_valid, alu_hi, alu_out, {v, c, n, z});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL busy_reset_no_pulse cycle %0d: got %b expected 0", i, out_valid);
      end
    end
    @(negedge clk);
    reset_n  = 1'b1;
    op_sel   = 4'd0;
    op_a     = 16'h0005;
    op_b     = 16'h0003;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || alu_out !== 16'h0008 || {v, c, n, z} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL first_accept_after_reset: got %b %h %b expected 1 0008 0000",
               out_valid, alu_out, {v, c, n, z});
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_multicycle();
    test_hold();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
